// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/echo path: state encoding,
// frame constants and the bit-period helper used by both state machines.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // True on the last clock of a bit period (counter runs 0..clks_per_bit-1).
  function automatic logic bit_period_done(input logic [15:0] cnt,
                                           input logic [15:0] clks_per_bit);
    return (cnt == (clks_per_bit - 16'd1));
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronizer followed by an 8N1, MSB-first
// framing state machine. Emits a registered one-cycle rx_valid strobe
// together with the received byte when the stop bit is high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam logic [15:0] CPB  = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

  logic        r_sync1;
  logic        r_sync2;
  uart_state_t r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shreg;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid;

  logic        w_rx_s;
  uart_state_t w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_bitcnt_nxt;
  logic [7:0]  w_shreg_nxt;
  logic [7:0]  w_rx_byte_nxt;
  logic        w_rx_valid_nxt;

  assign w_rx_s   = r_sync2;
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;

  // Bring the asynchronous pin into the clock domain; idle-high on reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic. With a zero half-period the start bit is already
  // verified by the falling-edge detect itself, so START is skipped.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bitcnt_nxt   = r_bitcnt;
    w_shreg_nxt    = r_shreg;
    w_rx_byte_nxt  = r_rx_byte;
    w_rx_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_s == 1'b0) begin
          w_bitcnt_nxt = 3'd0;
          if (HALF == 16'd0) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = 16'd0;
          end else begin
            w_state_nxt = START;
            w_cnt_nxt   = 16'd1;
          end
        end else begin
          w_cnt_nxt = 16'd0;
        end
      end
      START: begin
        if (r_cnt == HALF) begin
          w_cnt_nxt = 16'd0;
          if (w_rx_s == 1'b1) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt  = DATA;
            w_bitcnt_nxt = 3'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_period_done(r_cnt, CPB)) begin
          w_cnt_nxt   = 16'd0;
          w_shreg_nxt = {r_shreg[6:0], w_rx_s};
          if (r_bitcnt == 3'(DATA_BITS - 1)) begin
            w_state_nxt  = STOP;
            w_bitcnt_nxt = 3'd0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_period_done(r_cnt, CPB)) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = IDLE;
          if (w_rx_s == STOP_LEVEL) begin
            w_rx_valid_nxt = 1'b1;
            w_rx_byte_nxt  = r_shreg;
          end else begin
            w_rx_valid_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_cnt_nxt    = 16'd0;
        w_bitcnt_nxt = 3'd0;
      end
    endcase
  end

  // Receiver state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 16'd0;
      r_bitcnt   <= 3'd0;
      r_shreg    <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_rx_byte  <= w_rx_byte_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

endmodule

// File: rtl/top.sv
// UART-to-LED top: receives bytes from the Bluetooth module, latches each
// good byte onto the LEDs and echoes it back. The echo is dropped when a
// new byte arrives while the transmitter is still busy.
module top
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1,
  parameter logic [7:0] LED_RESET    = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] leds
);

  localparam logic [15:0] CPB = 16'(CLKS_PER_BIT);

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;

  uart_state_t r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bitcnt;
  logic [7:0]  r_tx_shreg;
  logic        r_tx;
  logic [7:0]  r_leds;

  uart_state_t w_tx_state_nxt;
  logic [15:0] w_tx_cnt_nxt;
  logic [2:0]  w_tx_bitcnt_nxt;
  logic [7:0]  w_tx_shreg_nxt;
  logic        w_tx_bit;

  assign uart_tx = r_tx;
  assign leds    = r_leds;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_pin   (uart_rx),
    .rx_byte  (w_rx_byte),
    .rx_valid (w_rx_valid)
  );

  // Line level for the current TX state; registered one edge later so the
  // start bit follows the LED update by exactly one clock.
  always_comb begin
    w_tx_bit = IDLE_LEVEL;
    case (r_tx_state)
      IDLE:    w_tx_bit = IDLE_LEVEL;
      START:   w_tx_bit = 1'b0;
      DATA:    w_tx_bit = r_tx_shreg[7];
      STOP:    w_tx_bit = STOP_LEVEL;
      default: w_tx_bit = IDLE_LEVEL;
    endcase
  end

  // TX next-state logic: accepts a byte only when idle, then walks
  // start, eight data bits MSB first, and stop.
  always_comb begin
    w_tx_state_nxt  = r_tx_state;
    w_tx_cnt_nxt    = r_tx_cnt;
    w_tx_bitcnt_nxt = r_tx_bitcnt;
    w_tx_shreg_nxt  = r_tx_shreg;
    case (r_tx_state)
      IDLE: begin
        if (w_rx_valid) begin
          w_tx_state_nxt  = START;
          w_tx_cnt_nxt    = 16'd0;
          w_tx_bitcnt_nxt = 3'd0;
          w_tx_shreg_nxt  = w_rx_byte;
        end else begin
          w_tx_cnt_nxt = 16'd0;
        end
      end
      START: begin
        if (bit_period_done(r_tx_cnt, CPB)) begin
          w_tx_cnt_nxt    = 16'd0;
          w_tx_bitcnt_nxt = 3'd0;
          w_tx_state_nxt  = DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_period_done(r_tx_cnt, CPB)) begin
          w_tx_cnt_nxt   = 16'd0;
          w_tx_shreg_nxt = {r_tx_shreg[6:0], 1'b0};
          if (r_tx_bitcnt == 3'(DATA_BITS - 1)) begin
            w_tx_state_nxt  = STOP;
            w_tx_bitcnt_nxt = 3'd0;
          end else begin
            w_tx_bitcnt_nxt = r_tx_bitcnt + 3'd1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_period_done(r_tx_cnt, CPB)) begin
          w_tx_cnt_nxt   = 16'd0;
          w_tx_state_nxt = IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      default: begin
        w_tx_state_nxt  = IDLE;
        w_tx_cnt_nxt    = 16'd0;
        w_tx_bitcnt_nxt = 3'd0;
      end
    endcase
  end

  // TX state register and registered serial output.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_tx_state  <= IDLE;
      r_tx_cnt    <= 16'd0;
      r_tx_bitcnt <= 3'd0;
      r_tx_shreg  <= 8'h00;
      r_tx        <= IDLE_LEVEL;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_tx_bitcnt <= w_tx_bitcnt_nxt;
      r_tx_shreg  <= w_tx_shreg_nxt;
      r_tx        <= w_tx_bit;
    end
  end

  // LED register: captures every correctly framed byte, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_leds <= LED_RESET;
    end else if (w_rx_valid) begin
      r_leds <= w_rx_byte;
    end else begin
      r_leds <= r_leds;
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for top: one instance at 1 clock/bit, one at 4 clocks/bit
// with a non-zero LED reset value. Outputs are sampled 1 time unit after
// each rising edge.
module tb_top;

  logic       clk;
  logic       reset_n;
  logic       rx1;
  logic       rx4;
  logic       tx1;
  logic       tx4;
  logic [7:0] leds1;
  logic [7:0] leds4;

  int total;
  int bad;

  logic [7:0] cap_leds [0:127];
  logic       cap_tx   [0:127];

  top #(.CLKS_PER_BIT(1), .LED_RESET(8'h00)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .uart_rx (rx1),
    .uart_tx (tx1),
    .leds    (leds1)
  );

  top #(.CLKS_PER_BIT(4), .LED_RESET(8'h96)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .uart_rx (rx4),
    .uart_tx (tx4),
    .leds    (leds4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pin image of one frame: index 0 is the start bit, 1..8 are bits 7..0.
  function automatic logic [9:0] frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[7 - i];
    f[9] = stop;
    return f;
  endfunction

  // Drive pins[k] for cpb cycles each, then idle high; capture after each edge.
  // Capture index k is taken just after edge t0+k.
  task automatic run(input bit use4, input logic [63:0] pins, input int npins,
                     input int cpb, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      logic p;
      p = ((k / cpb) < npins) ? pins[k / cpb] : 1'b1;
      if (use4) rx4 = p;
      else rx1 = p;
      tick();
      cap_leds[k] = use4 ? leds4 : leds1;
      cap_tx[k]   = use4 ? tx4 : tx1;
    end
    rx1 = 1'b1;
    rx4 = 1'b1;
  endtask

  initial begin
    logic [9:0] f;
    logic [9:0] a5_line;
    total   = 0;
    bad     = 0;
    reset_n = 1'b1;
    rx1     = 1'b1;
    rx4     = 1'b1;

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check8("rst_leds1", leds1, 8'h00);
      check1("rst_tx1", tx1, 1'b1);
      check8("rst_leds4", leds4, 8'h96);
      check1("rst_tx4", tx4, 1'b1);
    end
    reset_n = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check8("idle_leds1", leds1, 8'h00);
    check1("idle_tx1", tx1, 1'b1);

    // 0xA5 at 1 clock/bit: LEDs at t0+12, echo on t0+13..t0+22.
    a5_line = 10'b11_0100_1010;
    run(1'b0, 64'(frame(8'hA5, 1'b1)), 10, 1, 40);
    check8("a5_leds_before", cap_leds[11], 8'h00);
    check8("a5_leds", cap_leds[12], 8'hA5);
    check1("a5_tx_before_echo", cap_tx[12], 1'b1);
    for (int i = 0; i < 10; i++)
      check1($sformatf("a5_echo_bit%0d", i), cap_tx[13 + i], a5_line[i]);
    for (int k = 23; k < 40; k++)
      check1($sformatf("a5_tx_idle_k%0d", k), cap_tx[k], 1'b1);

    // 0x3C with a low stop bit: dropped, no echo.
    run(1'b0, 64'(frame(8'h3C, 1'b0)), 10, 1, 30);
    for (int k = 0; k < 30; k++) begin
      check8($sformatf("ferr_leds_k%0d", k), cap_leds[k], 8'hA5);
      check1($sformatf("ferr_tx_k%0d", k), cap_tx[k], 1'b1);
    end

    // 0x00 immediately followed by 0xFF: second echo dropped.
    run(1'b0, {44'h0, frame(8'hFF, 1'b1), frame(8'h00, 1'b1)}, 20, 1, 45);
    check8("b2b_leds_first", cap_leds[12], 8'h00);
    check8("b2b_leds_hold", cap_leds[21], 8'h00);
    check8("b2b_leds_second", cap_leds[22], 8'hFF);
    for (int k = 13; k < 22; k++)
      check1($sformatf("b2b_echo0_k%0d", k), cap_tx[k], 1'b0);
    for (int k = 22; k < 45; k++)
      check1($sformatf("b2b_no_ff_echo_k%0d", k), cap_tx[k], 1'b1);

    // 0x5A at 4 clocks/bit: stop sampled at t0+40, LEDs at t0+41.
    run(1'b1, 64'(frame(8'h5A, 1'b1)), 10, 4, 90);
    check8("c4_leds_before", cap_leds[40], 8'h96);
    check8("c4_leds", cap_leds[41], 8'h5A);
    check1("c4_tx_before", cap_tx[41], 1'b1);
    check1("c4_tx_start_first", cap_tx[42], 1'b0);
    check1("c4_tx_start_last", cap_tx[45], 1'b0);
    check1("c4_tx_bit7", cap_tx[46], 1'b0);
    check1("c4_tx_bit6", cap_tx[50], 1'b1);
    check1("c4_tx_bit5", cap_tx[54], 1'b0);
    check1("c4_tx_bit0", cap_tx[77], 1'b0);
    check1("c4_tx_stop", cap_tx[78], 1'b1);

    // Single-cycle low glitch at 4 clocks/bit.
    run(1'b1, 64'h0, 1, 1, 60);
    for (int k = 0; k < 60; k++) begin
      check8($sformatf("glitch_leds_k%0d", k), cap_leds[k], 8'h5A);
      check1($sformatf("glitch_tx_k%0d", k), cap_tx[k], 1'b1);
    end

    // Reset asserted while data bit 4 of 0x81 is on the pin.
    f = frame(8'h81, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rx1 = f[k];
      tick();
    end
    rx1     = f[4];
    reset_n = 1'b1;
    tick();
    tick();
    rx1     = 1'b1;
    reset_n = 1'b0;
    check8("midrst_leds1", leds1, 8'h00);
    check1("midrst_tx1", tx1, 1'b1);
    check8("midrst_leds4", leds4, 8'h96);
    for (int i = 0; i < 10; i++) tick();
    check8("midrst_leds1_idle", leds1, 8'h00);

    // 0x42 after the aborted frame.
    f = frame(8'h42, 1'b1);
    run(1'b0, 64'(f), 10, 1, 30);
    check8("r42_leds_before", cap_leds[11], 8'h00);
    check8("r42_leds", cap_leds[12], 8'h42);
    for (int i = 0; i < 10; i++)
      check1($sformatf("r42_echo_bit%0d", i), cap_tx[13 + i], f[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
